spi_fifo_drain_master: RTL and testbench

- Consumer at the read port of the async FIFO: pops one DATA_WIDTH word at a time and transmits it as an SPI mode-0 (CPOL=0, CPHA=0), MSB-first frame.
- Captures MISO into a receive word per frame and reports it with a one-cycle valid pulse.
- Runs entirely in the FIFO read-clock domain.

---
 rtl/spi_fifo_drain_master.sv | 205 ++++++++++++++++++++
 tb/tb_spi_fifo_drain_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fifo_drain_master.sv
// ---------------------------------------------------------------------------
// spi_fifo_drain_master
//
// Drains an async FIFO from its read side and sends each word as one
// SPI mode-0 (CPOL=0, CPHA=0), MSB-first frame. MISO is shifted into a
// receive word that is presented on rx_data with a one-cycle rx_valid.
// Everything runs in the FIFO read-clock domain.
//
// Ports:
//   rd_clk        FIFO read clock
//   rd_rst_n      asynchronous active-low reset
//   en            permit new frames
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO pop request (high only in POP)
//   fifo_rd_data  FIFO read data, valid the cycle after an accepted pop
//   spi_sclk      serial clock, idles low
//   spi_cs_n      chip select, active low
//   spi_mosi      serial data out
//   spi_miso      serial data in (already synchronous to rd_clk)
//   rx_data       last received word
//   rx_valid      one-cycle pulse when rx_data updates
//   busy          high in every state except IDLE
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for en=1 and a non-empty FIFO
// POP    | fifo_rd_en high for this single cycle
// LOAD   | capture popped word, drive first MOSI bit, drop spi_cs_n
// LEAD   | CLK_DIV cycles of CS setup with SCLK low; first rise on exit
// SHIFT  | SCLK toggles every CLK_DIV cycles until all bits are exchanged
// TRAIL  | CLK_DIV cycles of CS hold; on exit publish rx word, raise CS
// GAP    | CS_GAP cycles with CS high; the last cycle also makes the IDLE
//        | start decision so back-to-back pops are 1+1+cs_low+CS_GAP apart
// ---------------------------------------------------------------------------
module spi_fifo_drain_master #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4,
    parameter int CS_GAP     = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  spi_sclk,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_LEAD  = 3'd3,
        S_SHIFT = 3'd4,
        S_TRAIL = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    state_t                state;
    logic [DIV_W-1:0]      div_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [BIT_W-1:0]      bit_cnt;     // counts completed falling edges
    // The bit currently on the wire lives in spi_mosi, so the shifter only
    // keeps the bits still to be sent.
    logic [DATA_WIDTH-2:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  div_wrap;

    assign div_wrap = (div_cnt == DIV_LAST);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            fifo_rd_en <= 1'b0;
            spi_sclk   <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_mosi   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en && !fifo_empty) begin
                        state      <= S_POP;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                S_POP: begin
                    fifo_rd_en <= 1'b0;
                    if (fifo_empty) begin
                        // pop rejected by the FIFO; nothing will arrive
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    tx_shift <= fifo_rd_data[DATA_WIDTH-2:0];
                    spi_mosi <= fifo_rd_data[DATA_WIDTH-1];
                    spi_cs_n <= 1'b0;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    state    <= S_LEAD;
                end

                S_LEAD: begin
                    if (div_wrap) begin
                        div_cnt  <= '0;
                        spi_sclk <= 1'b1;
                        rx_shift <= {rx_shift[DATA_WIDTH-2:0], spi_miso};
                        state    <= S_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        if (spi_sclk) begin
                            spi_sclk <= 1'b0;
                            bit_cnt  <= bit_cnt + 1'b1;
                            // after the final falling edge the LSB just stays put
                            if (bit_cnt != BIT_LAST) begin
                                tx_shift <= tx_shift << 1;
                                spi_mosi <= tx_shift[DATA_WIDTH-2];
                            end
                        end else if (bit_cnt == BIT_ALL) begin
                            // last low half-period done; SCLK already low
                            state <= S_TRAIL;
                        end else begin
                            spi_sclk <= 1'b1;
                            rx_shift <= {rx_shift[DATA_WIDTH-2:0], spi_miso};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_TRAIL: begin
                    if (div_wrap) begin
                        div_cnt  <= '0;
                        spi_cs_n <= 1'b1;
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                        gap_cnt  <= '0;
                        state    <= S_GAP;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (en && !fifo_empty) begin
                            state      <= S_POP;
                            fifo_rd_en <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    fifo_rd_en <= 1'b0;
                    spi_sclk   <= 1'b0;
                    spi_cs_n   <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fifo_drain_master.sv
// ---------------------------------------------------------------------------
// tb_spi_fifo_drain_master
//
// Two instances: "a" with default parameters (MISO looped to MOSI) and "b"
// with DATA_WIDTH=8, CLK_DIV=1 (MISO tied high). Each has a small FIFO
// model and a negedge monitor. Expected receive words are pushed into a
// scoreboard queue when stimulus is queued and popped on rx_valid.
// ---------------------------------------------------------------------------
module tb_spi_fifo_drain_master;

    localparam int DW   = 32;
    localparam int DWB  = 8;
    localparam int CS_LOW_A  = 4 + 2 * 4 * DW + 4;   // 264
    localparam int CS_LOW_B  = 1 + 2 * 1 * DWB + 1;  // 18
    localparam int POP_SPACE = 1 + 1 + CS_LOW_A + 2; // 268
    localparam int CS_HIGH_BETWEEN = 2 + 2;          // GAP + POP + LOAD

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;

    // ---------------- instance a ----------------
    logic          en_a, empty_a, rd_en_a, sclk_a, cs_a, mosi_a, miso_a, rxv_sig_a, busy_a;
    logic [DW-1:0] rd_data_a, rx_data_a;
    logic [DW-1:0] fq_a[$];
    logic [DW-1:0] sb_a[$];

    assign miso_a = mosi_a;

    spi_fifo_drain_master dut_a (
        .rd_clk(clk), .rd_rst_n(rst_n), .en(en_a), .fifo_empty(empty_a),
        .fifo_rd_en(rd_en_a), .fifo_rd_data(rd_data_a),
        .spi_sclk(sclk_a), .spi_cs_n(cs_a), .spi_mosi(mosi_a), .spi_miso(miso_a),
        .rx_data(rx_data_a), .rx_valid(rxv_sig_a), .busy(busy_a)
    );

    // ---------------- instance b ----------------
    logic           en_b, empty_b, rd_en_b, sclk_b, cs_b, mosi_b, miso_b, rxv_sig_b, busy_b;
    logic [DWB-1:0] rd_data_b, rx_data_b;
    logic [DWB-1:0] fq_b[$];
    logic [DWB-1:0] sb_b[$];

    assign miso_b = 1'b1;

    spi_fifo_drain_master #(.DATA_WIDTH(DWB), .CLK_DIV(1), .CS_GAP(2)) dut_b (
        .rd_clk(clk), .rd_rst_n(rst_n), .en(en_b), .fifo_empty(empty_b),
        .fifo_rd_en(rd_en_b), .fifo_rd_data(rd_data_b),
        .spi_sclk(sclk_b), .spi_cs_n(cs_b), .spi_mosi(mosi_b), .spi_miso(miso_b),
        .rx_data(rx_data_b), .rx_valid(rxv_sig_b), .busy(busy_b)
    );

    // ---------------- FIFO models ----------------
    initial begin
        empty_a   = 1'b1;
        empty_b   = 1'b1;
        rd_data_a = '0;
        rd_data_b = '0;
    end

    always @(posedge clk) begin
        if (rd_en_a && fq_a.size() > 0) rd_data_a <= fq_a.pop_front();
        if (rd_en_b && fq_b.size() > 0) rd_data_b <= fq_b.pop_front();
    end

    always @(negedge clk) begin
        empty_a = (fq_a.size() == 0);
        empty_b = (fq_b.size() == 0);
    end

    // ---------------- monitor a ----------------
    int            pops_a = 0, frames_a = 0, rxv_a = 0, rises_a = 0, cs_len_a = 0, high_a = 0;
    int            last_cs_len_a = 0, last_rises_a = 0, last_high_a = 0;
    int            last_pop_cyc_a = 0, pop_gap_a = 0;
    logic [DW-1:0] mosi_w_a = '0, last_mosi_a = '0;
    logic          prev_sclk_a = 1'b0, prev_cs_a = 1'b1;

    always @(negedge clk) begin
        logic [DW-1:0] exp;
        cyc++;
        if (!rst_n) begin
            cs_len_a    = 0;
            rises_a     = 0;
            prev_sclk_a = 1'b0;
            prev_cs_a   = 1'b1;
        end else begin
            if (rd_en_a) begin
                pops_a++;
                pop_gap_a      = cyc - last_pop_cyc_a;
                last_pop_cyc_a = cyc;
            end
            if (sclk_a && !prev_sclk_a) begin
                rises_a++;
                mosi_w_a = {mosi_w_a[DW-2:0], mosi_a};
            end
            if (!cs_a) begin
                if (prev_cs_a) begin
                    last_high_a = high_a;
                    cs_len_a    = 0;
                end
                cs_len_a++;
                high_a = 0;
            end else begin
                high_a++;
                if (!prev_cs_a) begin
                    last_cs_len_a = cs_len_a;
                    last_rises_a  = rises_a;
                    last_mosi_a   = mosi_w_a;
                    cs_len_a      = 0;
                    rises_a       = 0;
                    frames_a++;
                end
            end
            if (rxv_sig_a) begin
                rxv_a++;
                checks++;
                if (sb_a.size() == 0) begin
                    $display("FAIL rx_a_unexpected: got rx_data=%h, required no rx_valid", rx_data_a);
                end else begin
                    exp = sb_a.pop_front();
                    if (rx_data_a !== exp)
                        $display("FAIL rx_a_data: got %h, required %h", rx_data_a, exp);
                    else
                        passed++;
                end
            end
            prev_sclk_a = sclk_a;
            prev_cs_a   = cs_a;
        end
    end

    // ---------------- monitor b ----------------
    int             frames_b = 0, rxv_b = 0, rises_b = 0, cs_len_b = 0, last_rise_b = 0, rise_bad_b = 0;
    int             last_cs_len_b = 0, last_rises_b = 0;
    logic [DWB-1:0] mosi_w_b = '0, last_mosi_b = '0;
    logic           prev_sclk_b = 1'b0, prev_cs_b = 1'b1;

    always @(negedge clk) begin
        logic [DWB-1:0] exp;
        if (!rst_n) begin
            cs_len_b    = 0;
            rises_b     = 0;
            prev_sclk_b = 1'b0;
            prev_cs_b   = 1'b1;
        end else begin
            if (sclk_b && !prev_sclk_b) begin
                if (rises_b > 0 && (cyc - last_rise_b) != 2) rise_bad_b++;
                last_rise_b = cyc;
                rises_b++;
                mosi_w_b = {mosi_w_b[DWB-2:0], mosi_b};
            end
            if (!cs_b) begin
                cs_len_b++;
            end else if (!prev_cs_b) begin
                last_cs_len_b = cs_len_b;
                last_rises_b  = rises_b;
                last_mosi_b   = mosi_w_b;
                cs_len_b      = 0;
                rises_b       = 0;
                frames_b++;
            end
            if (rxv_sig_b) begin
                rxv_b++;
                checks++;
                if (sb_b.size() == 0) begin
                    $display("FAIL rx_b_unexpected: got rx_data=%h, required no rx_valid", rx_data_b);
                end else begin
                    exp = sb_b.pop_front();
                    if (rx_data_b !== exp)
                        $display("FAIL rx_b_data: got %h, required %h", rx_data_b, exp);
                    else
                        passed++;
                end
            end
            prev_sclk_b = sclk_b;
            prev_cs_b   = cs_b;
        end
    end

    // ---------------- tests ----------------
    task automatic wait_frames_a(input int target, input string name);
        int i = 0;
        while (frames_a < target && i < 3000) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (frames_a < target)
            $display("FAIL %s_timeout: frames=%0d, required %0d", name, frames_a, target);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (rd_en_a !== 1'b0) $display("FAIL reset_rd_en: got %b, required 0", rd_en_a); else passed++;
        if (sclk_a !== 1'b0) $display("FAIL reset_sclk: got %b, required 0", sclk_a); else passed++;
        if (cs_a !== 1'b1) $display("FAIL reset_cs_n: got %b, required 1", cs_a); else passed++;
        if (mosi_a !== 1'b0) $display("FAIL reset_mosi: got %b, required 0", mosi_a); else passed++;
        if (rx_data_a !== '0) $display("FAIL reset_rx_data: got %h, required 0", rx_data_a); else passed++;
        if (rxv_sig_a !== 1'b0) $display("FAIL reset_rx_valid: got %b, required 0", rxv_sig_a); else passed++;
        if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy_a); else passed++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle_empty();
        int bad_rd = 0, bad_sclk = 0, bad_busy = 0, bad_cs = 0;
        en_a = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rd_en_a !== 1'b0) bad_rd++;
            if (sclk_a !== 1'b0) bad_sclk++;
            if (busy_a !== 1'b0) bad_busy++;
            if (cs_a !== 1'b1) bad_cs++;
        end
        checks += 4;
        if (bad_rd != 0) $display("FAIL empty_rd_en: %0d cycles high, required 0", bad_rd); else passed++;
        if (bad_sclk != 0) $display("FAIL empty_sclk: %0d cycles high, required 0", bad_sclk); else passed++;
        if (bad_busy != 0) $display("FAIL empty_busy: %0d cycles high, required 0", bad_busy); else passed++;
        if (bad_cs != 0) $display("FAIL empty_cs_n: %0d cycles low, required 0", bad_cs); else passed++;
    endtask

    task automatic test_single_frame();
        logic [DW-1:0] w = 32'hA5C3_0F81;
        int p0 = pops_a, f0 = frames_a, r0 = rxv_a;
        sb_a.push_back(w);
        fq_a.push_back(w);
        wait_frames_a(f0 + 1, "single");
        repeat (20) @(negedge clk);
        checks += 6;
        if (pops_a - p0 != 1) $display("FAIL single_pops: got %0d, required 1", pops_a - p0); else passed++;
        if (last_cs_len_a != CS_LOW_A) $display("FAIL single_cs_low: got %0d, required %0d", last_cs_len_a, CS_LOW_A); else passed++;
        if (last_rises_a != DW) $display("FAIL single_rises: got %0d, required %0d", last_rises_a, DW); else passed++;
        if (last_mosi_a !== w) $display("FAIL single_mosi: got %h, required %h", last_mosi_a, w); else passed++;
        if (rxv_a - r0 != 1) $display("FAIL single_rx_count: got %0d, required 1", rxv_a - r0); else passed++;
        if (busy_a !== 1'b0) $display("FAIL single_busy: got %b, required 0", busy_a); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w[2];
        int p0 = pops_a, f0 = frames_a;
        w[0] = 32'h0000_0001;
        w[1] = 32'hFFFF_FFFE;
        for (int k = 0; k < 2; k++) begin
            sb_a.push_back(w[k]);
            fq_a.push_back(w[k]);
        end
        for (int k = 0; k < 2; k++) begin
            wait_frames_a(f0 + k + 1, "b2b");
            checks += 2;
            if (last_mosi_a !== w[k]) $display("FAIL b2b_mosi%0d: got %h, required %h", k, last_mosi_a, w[k]); else passed++;
            if (last_cs_len_a != CS_LOW_A) $display("FAIL b2b_cs_low%0d: got %0d, required %0d", k, last_cs_len_a, CS_LOW_A); else passed++;
        end
        repeat (20) @(negedge clk);
        checks += 3;
        if (pops_a - p0 != 2) $display("FAIL b2b_pops: got %0d, required 2", pops_a - p0); else passed++;
        if (pop_gap_a != POP_SPACE) $display("FAIL b2b_pop_spacing: got %0d, required %0d", pop_gap_a, POP_SPACE); else passed++;
        if (last_high_a != CS_HIGH_BETWEEN) $display("FAIL b2b_cs_high: got %0d, required %0d", last_high_a, CS_HIGH_BETWEEN); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w_drop = 32'hDEAD_BEEF;
        logic [DW-1:0] w_keep = 32'h1234_5678;
        int i = 0;
        int f0, r0;
        fq_a.push_back(w_drop);
        fq_a.push_back(w_keep);
        sb_a.push_back(w_keep);
        while (rises_a < 10 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (rises_a < 10) $display("FAIL rstmid_timeout: rises=%0d, required 10", rises_a); else passed++;
        f0 = frames_a;
        r0 = rxv_a;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (cs_a !== 1'b1) $display("FAIL rstmid_cs_n: got %b, required 1", cs_a); else passed++;
        if (sclk_a !== 1'b0) $display("FAIL rstmid_sclk: got %b, required 0", sclk_a); else passed++;
        if (busy_a !== 1'b0) $display("FAIL rstmid_busy: got %b, required 0", busy_a); else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (cs_a !== 1'b1) $display("FAIL rstmid_cs_hold: got %b, required 1", cs_a); else passed++;
        rst_n = 1'b1;
        wait_frames_a(f0 + 1, "rstmid");
        repeat (20) @(negedge clk);
        checks += 3;
        if (last_mosi_a !== w_keep) $display("FAIL rstmid_mosi: got %h, required %h", last_mosi_a, w_keep); else passed++;
        if (last_cs_len_a != CS_LOW_A) $display("FAIL rstmid_cs_low: got %0d, required %0d", last_cs_len_a, CS_LOW_A); else passed++;
        if (rxv_a - r0 != 1) $display("FAIL rstmid_rx_count: got %0d, required 1", rxv_a - r0); else passed++;
    endtask

    task automatic test_en_drop();
        int p0 = pops_a, f0 = frames_a, i = 0;
        logic [DW-1:0] w[3];
        w[0] = 32'hC0DE_0001;
        w[1] = 32'hC0DE_0002;
        w[2] = 32'hC0DE_0003;
        sb_a.push_back(w[0]);
        for (int k = 0; k < 3; k++) fq_a.push_back(w[k]);
        while (cs_a !== 1'b0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        en_a = 1'b0;
        wait_frames_a(f0 + 1, "endrop");
        repeat (300) @(negedge clk);
        checks += 5;
        if (pops_a - p0 != 1) $display("FAIL endrop_pops: got %0d, required 1", pops_a - p0); else passed++;
        if (frames_a - f0 != 1) $display("FAIL endrop_frames: got %0d, required 1", frames_a - f0); else passed++;
        if (busy_a !== 1'b0) $display("FAIL endrop_busy: got %b, required 0", busy_a); else passed++;
        if (fq_a.size() != 2) $display("FAIL endrop_fifo_left: got %0d, required 2", fq_a.size()); else passed++;
        if (last_mosi_a !== w[0]) $display("FAIL endrop_mosi: got %h, required %h", last_mosi_a, w[0]); else passed++;
        fq_a.delete();
    endtask

    task automatic test_small();
        int f0 = frames_b, r0 = rxv_b, i = 0;
        fq_b.push_back(8'h3C);
        sb_b.push_back(8'hFF);
        en_b = 1'b1;
        while (frames_b < f0 + 1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        repeat (10) @(negedge clk);
        checks += 6;
        if (frames_b - f0 != 1) $display("FAIL small_frames: got %0d, required 1", frames_b - f0); else passed++;
        if (last_cs_len_b != CS_LOW_B) $display("FAIL small_cs_low: got %0d, required %0d", last_cs_len_b, CS_LOW_B); else passed++;
        if (last_rises_b != DWB) $display("FAIL small_rises: got %0d, required %0d", last_rises_b, DWB); else passed++;
        if (rise_bad_b != 0) $display("FAIL small_sclk_period: %0d bad spacings, required 0", rise_bad_b); else passed++;
        if (last_mosi_b !== 8'h3C) $display("FAIL small_mosi: got %h, required 3c", last_mosi_b); else passed++;
        if (rxv_b - r0 != 1) $display("FAIL small_rx_count: got %0d, required 1", rxv_b - r0); else passed++;
        en_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_empty();
        test_single_frame();
        test_back_to_back();
        test_reset_mid();
        test_en_drop();
        test_small();
        checks += 2;
        if (sb_a.size() != 0) $display("FAIL sb_a_leftover: got %0d entries, required 0", sb_a.size()); else passed++;
        if (sb_b.size() != 0) $display("FAIL sb_b_leftover: got %0d entries, required 0", sb_b.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
